// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: samples the PC, reads instruction memory over req/ack and hands the word to decode
module instr_fetch_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              pc_advance,
  output logic              fetch_error
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic discard, discard_n, req_n, valid_n, adv_n, err_n;
  logic [ADDR_W-1:0] addr_n, ipc_n;
  logic [DATA_W-1:0] out_n;
  wire misaligned = pc_in[1:0] != 2'b00;
  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    discard_n = discard;
    req_n     = imem_req;
    addr_n    = imem_addr;
    valid_n   = instr_valid;
    out_n     = instr_out;
    ipc_n     = instr_pc;
    adv_n     = 1'b0;
    err_n     = fetch_error;
    case (state)
      IDLE: if (fetch_en && !flush) begin
        if (misaligned) begin
          state_n = ERROR;
          err_n   = 1'b1;
        end else begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = pc_in;
        end
      end
      REQ: if (imem_ack) begin
        req_n     = 1'b0;
        cnt_n     = '0;
        discard_n = 1'b0;
        if (discard || flush) state_n = IDLE;
        else begin
          state_n = HOLD;
          valid_n = 1'b1;
          out_n   = imem_rdata;
          ipc_n   = imem_addr;
          adv_n   = 1'b1;
        end
      end else if (cnt == TO_LAST) begin
        state_n   = ERROR;
        req_n     = 1'b0;
        err_n     = 1'b1;
        cnt_n     = '0;
        discard_n = 1'b0;
      end else begin
        cnt_n     = cnt + 16'd1;
        discard_n = discard | flush;
      end
      HOLD: if (flush) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end else if (instr_ready) begin
        valid_n = 1'b0;
        state_n = IDLE;
        if (fetch_en && misaligned) begin
          state_n = ERROR;
          err_n   = 1'b1;
        end else if (fetch_en) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = pc_in;
        end
      end
      default: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
        err_n   = 1'b1;
      end
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      pc_advance  <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      discard     <= discard_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      instr_valid <= valid_n;
      instr_out   <= out_n;
      instr_pc    <= ipc_n;
      pc_advance  <= adv_n;
      fetch_error <= err_n;
    end
endmodule
